// File: rtl/y86_pkg.sv
// y86_pkg: shared constants and the W pipeline register layout
// for the write-back end of the Y86-64 PIPE datapath.
package y86_pkg;
    localparam int XLEN  = 64;
    localparam int NREGS = 15;

    localparam logic [3:0] SBUB = 4'd0;
    localparam logic [3:0] SAOK = 4'd1;
    localparam logic [3:0] SHLT = 4'd2;
    localparam logic [3:0] SADR = 4'd3;
    localparam logic [3:0] SINS = 4'd4;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef struct packed {
        logic [3:0]      stat;
        logic [3:0]      icode;
        logic [3:0]      dstE;
        logic [3:0]      dstM;
        logic [XLEN-1:0] valE;
        logic [XLEN-1:0] valM;
    } wreg_t;

    localparam wreg_t W_BUBBLE = '{stat: SBUB, icode: INOP, dstE: RNONE, dstM: RNONE, valE: '0, valM: '0};

    function automatic logic is_exc(input logic [3:0] s);
        return (s == SHLT) || (s == SADR) || (s == SINS);
    endfunction
endpackage

// File: rtl/y86_regfile.sv
// y86_regfile: 15-entry architectural register file, two write ports
// (M wins over E on the same id) and three combinational read ports.
module y86_regfile
    import y86_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [3:0]      e_dst_i,
    input  logic [XLEN-1:0] e_val_i,
    input  logic [3:0]      m_dst_i,
    input  logic [XLEN-1:0] m_val_i,
    input  logic [3:0]      a_addr_i,
    input  logic [3:0]      b_addr_i,
    input  logic [3:0]      dbg_addr_i,
    output logic [XLEN-1:0] a_data_o,
    output logic [XLEN-1:0] b_data_o,
    output logic [XLEN-1:0] dbg_data_o
);
    logic [XLEN-1:0] regs_q [NREGS];

    // M port assigned last so popq %rsp keeps the loaded value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            if (e_dst_i != RNONE) regs_q[e_dst_i] <= e_val_i;
            if (m_dst_i != RNONE) regs_q[m_dst_i] <= m_val_i;
        end
    end

    assign a_data_o   = (a_addr_i == RNONE)   ? '0 : regs_q[a_addr_i];
    assign b_data_o   = (b_addr_i == RNONE)   ? '0 : regs_q[b_addr_i];
    assign dbg_data_o = (dbg_addr_i == RNONE) ? '0 : regs_q[dbg_addr_i];
endmodule

// File: rtl/pipe_writeback.sv
// pipe_writeback: W pipeline register, stall/bubble/freeze control and
// processor status, feeding the architectural register file.
module pipe_writeback
    import y86_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            W_stall,
    input  logic            W_bubble,
    input  logic [3:0]      m_stat,
    input  logic [3:0]      M_icode,
    input  logic [3:0]      M_dstE,
    input  logic [3:0]      M_dstM,
    input  logic [XLEN-1:0] M_valE,
    input  logic [XLEN-1:0] m_valM,
    output logic [3:0]      W_stat,
    output logic [3:0]      W_icode,
    output logic [3:0]      W_dstE,
    output logic [3:0]      W_dstM,
    output logic [XLEN-1:0] W_valE,
    output logic [XLEN-1:0] W_valM,
    input  logic [3:0]      d_srcA,
    input  logic [3:0]      d_srcB,
    output logic [XLEN-1:0] d_rvalA,
    output logic [XLEN-1:0] d_rvalB,
    input  logic [3:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic [3:0]      Stat,
    output logic            halted
);
    wreg_t w_q, w_d, m_in;

    assign m_in = '{stat: m_stat, icode: M_icode, dstE: M_dstE, dstM: M_dstM, valE: M_valE, valM: m_valM};

    // an exceptional entry freezes W until reset; stall beats bubble
    always_comb begin
        w_d = (halted || W_stall) ? w_q : W_bubble ? W_BUBBLE : m_in;
    end

    always_ff @(posedge clk) begin
        if (rst) w_q <= W_BUBBLE;
        else     w_q <= w_d;
    end

    assign W_stat  = w_q.stat;
    assign W_icode = w_q.icode;
    assign W_dstE  = w_q.dstE;
    assign W_dstM  = w_q.dstM;
    assign W_valE  = w_q.valE;
    assign W_valM  = w_q.valM;
    assign halted  = is_exc(w_q.stat);
    assign Stat    = (w_q.stat == SBUB) ? SAOK : w_q.stat;

    y86_regfile u_rf (
        .clk        (clk),
        .rst        (rst),
        .we_i       (w_q.stat == SAOK),
        .e_dst_i    (w_q.dstE),
        .e_val_i    (w_q.valE),
        .m_dst_i    (w_q.dstM),
        .m_val_i    (w_q.valM),
        .a_addr_i   (d_srcA),
        .b_addr_i   (d_srcB),
        .dbg_addr_i (dbg_addr),
        .a_data_o   (d_rvalA),
        .b_data_o   (d_rvalB),
        .dbg_data_o (dbg_data)
    );
endmodule

// File: tb/tb_pipe_writeback.sv
// tb_pipe_writeback: scenario tasks with a scoreboard of expected register
// writes, popped and compared once the write has had time to commit.
module tb_pipe_writeback;
    import y86_pkg::*;

    logic            clk = 1'b0;
    logic            rst, W_stall, W_bubble;
    logic [3:0]      m_stat, M_icode, M_dstE, M_dstM;
    logic [63:0]     M_valE, m_valM;
    logic [3:0]      W_stat, W_icode, W_dstE, W_dstM;
    logic [63:0]     W_valE, W_valM;
    logic [3:0]      d_srcA, d_srcB, dbg_addr, Stat;
    logic [63:0]     d_rvalA, d_rvalB, dbg_data;
    logic            halted;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] val;
    } wr_t;
    wr_t exp_q[$];
    logic [63:0] model [15];

    pipe_writeback dut (
        .clk(clk), .rst(rst), .W_stall(W_stall), .W_bubble(W_bubble),
        .m_stat(m_stat), .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .M_valE(M_valE), .m_valM(m_valM),
        .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
        .W_valE(W_valE), .W_valM(W_valM),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .Stat(Stat), .halted(halted)
    );

    always #50 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input logic [3:0] st, input logic [3:0] ic, input logic [3:0] de,
                           input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
        m_stat = st; M_icode = ic; M_dstE = de; M_dstM = dm; M_valE = ve; m_valM = vm;
    endtask

    task automatic drive_nop();
        drive_m(SBUB, INOP, RNONE, RNONE, 64'd0, 64'd0);
    endtask

    // expected architectural effect of an instruction that will retire normally
    task automatic push_exp(input logic [3:0] st, input logic [3:0] de, input logic [3:0] dm,
                            input logic [63:0] ve, input logic [63:0] vm);
        if (st == SAOK) begin
            if (de != RNONE && de != dm) exp_q.push_back('{id: de, val: ve});
            if (dm != RNONE) exp_q.push_back('{id: dm, val: vm});
        end
    endtask

    task automatic drain_sb(input string tag);
        while (exp_q.size() > 0) begin
            wr_t e = exp_q.pop_front();
            model[e.id] = e.val;
            dbg_addr = e.id;
            #1;
            checks++;
            if (dbg_data !== e.val) begin
                errors++;
                $display("FAIL %s reg[%0d]: got %h expected %h", tag, e.id, dbg_data, e.val);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; W_stall = 1'b0; W_bubble = 1'b0;
        d_srcA = RNONE; d_srcB = RNONE; dbg_addr = 4'd0;
        drive_m(SAOK, IIRMOVQ, 4'd1, 4'd2, 64'hAAAA, 64'hBBBB);
        step();
        step();
        rst = 1'b0;
        drive_nop();
        for (int i = 0; i < 15; i++) model[i] = 64'd0;
        for (int i = 0; i < 15; i++) begin
            dbg_addr = 4'(i);
            #1;
            checks++;
            if (dbg_data !== 64'd0) begin
                errors++;
                $display("FAIL reset_reg[%0d]: got %h expected 0", i, dbg_data);
            end
        end
        checks++;
        if (W_stat !== SBUB || W_icode !== INOP || W_dstE !== RNONE || W_dstM !== RNONE) begin
            errors++;
            $display("FAIL reset_w: got stat=%h icode=%h dstE=%h dstM=%h expected 0/1/f/f",
                     W_stat, W_icode, W_dstE, W_dstM);
        end
        checks++;
        if (Stat !== SAOK || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_stat: got Stat=%h halted=%b expected 1/0", Stat, halted);
        end
    endtask

    task automatic test_irmovq();
        d_srcA = 4'd2;
        drive_m(SAOK, IIRMOVQ, 4'd2, RNONE, 64'h1234, 64'd0);
        push_exp(SAOK, 4'd2, RNONE, 64'h1234, 64'd0);
        step();
        drive_nop();
        checks++;
        if (d_rvalA !== 64'd0) begin
            errors++;
            $display("FAIL irmovq_edge1: got %h expected 0", d_rvalA);
        end
        checks++;
        if (W_stat !== SAOK || W_dstE !== 4'd2 || W_valE !== 64'h1234) begin
            errors++;
            $display("FAIL irmovq_wreg: got stat=%h dstE=%h valE=%h expected 1/2/1234", W_stat, W_dstE, W_valE);
        end
        step();
        checks++;
        if (d_rvalA !== 64'h1234) begin
            errors++;
            $display("FAIL irmovq_edge2: got %h expected 1234", d_rvalA);
        end
        drain_sb("irmovq");
    endtask

    task automatic test_popq();
        drive_m(SAOK, IPOPQ, RRSP, RRSP, 64'h108, 64'hDEAD);
        push_exp(SAOK, RRSP, RRSP, 64'h108, 64'hDEAD);
        step();
        drive_nop();
        step();
        drain_sb("popq_rsp");
        drive_m(SAOK, IRMMOVQ, RNONE, RNONE, 64'h999, 64'h777);
        step();
        drive_nop();
        step();
        for (int i = 0; i < 15; i++) begin
            dbg_addr = 4'(i);
            #1;
            checks++;
            if (dbg_data !== model[i]) begin
                errors++;
                $display("FAIL rmmovq_nochange reg[%0d]: got %h expected %h", i, dbg_data, model[i]);
            end
        end
        drive_m(SAOK, IMRMOVQ, 4'd8, 4'd9, 64'h8888, 64'h9999);
        push_exp(SAOK, 4'd8, 4'd9, 64'h8888, 64'h9999);
        step();
        drive_nop();
        step();
        drain_sb("dual_port");
    endtask

    task automatic test_stall_bubble();
        drive_m(SAOK, IIRMOVQ, 4'd5, RNONE, 64'h50, 64'd0);
        push_exp(SAOK, 4'd5, RNONE, 64'h50, 64'd0);
        step();
        W_stall = 1'b1;
        dbg_addr = 4'd5;
        for (int i = 0; i < 3; i++) begin
            drive_m(SAOK, IIRMOVQ, 4'd5, RNONE, 64'h60 + 64'(i), 64'd0);
            step();
            checks++;
            if (W_valE !== 64'h50 || W_dstE !== 4'd5 || W_stat !== SAOK) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got valE=%h dstE=%h stat=%h expected 50/5/1", i, W_valE, W_dstE, W_stat);
            end
            checks++;
            if (dbg_data !== 64'h50) begin
                errors++;
                $display("FAIL stall_reg[%0d]: got %h expected 50", i, dbg_data);
            end
        end
        W_stall = 1'b0;
        drive_nop();
        step();
        drain_sb("stall");
        W_bubble = 1'b1;
        drive_m(SAOK, IIRMOVQ, 4'd6, RNONE, 64'h66, 64'd0);
        step();
        W_bubble = 1'b0;
        drive_nop();
        checks++;
        if (W_stat !== SBUB || W_dstE !== RNONE || W_icode !== INOP) begin
            errors++;
            $display("FAIL bubble_w: got stat=%h dstE=%h icode=%h expected 0/f/1", W_stat, W_dstE, W_icode);
        end
        step();
        dbg_addr = 4'd6;
        #1;
        checks++;
        if (dbg_data !== model[6]) begin
            errors++;
            $display("FAIL bubble_nowrite: got %h expected %h", dbg_data, model[6]);
        end
        drive_m(SAOK, IIRMOVQ, 4'd7, RNONE, 64'h77, 64'd0);
        push_exp(SAOK, 4'd7, RNONE, 64'h77, 64'd0);
        step();
        W_stall = 1'b1;
        W_bubble = 1'b1;
        drive_nop();
        step();
        checks++;
        if (W_stat !== SAOK || W_valE !== 64'h77 || W_dstE !== 4'd7) begin
            errors++;
            $display("FAIL stall_bubble: got stat=%h valE=%h dstE=%h expected 1/77/7", W_stat, W_valE, W_dstE);
        end
        W_stall = 1'b0;
        W_bubble = 1'b0;
        step();
        drain_sb("stall_bubble");
    endtask

    task automatic test_freeze();
        drive_m(SAOK, IIRMOVQ, 4'd3, RNONE, 64'h3333, 64'd0);
        push_exp(SAOK, 4'd3, RNONE, 64'h3333, 64'd0);
        step();
        drive_m(SADR, IMRMOVQ, RNONE, 4'd3, 64'd0, 64'hBAD);
        push_exp(SADR, RNONE, 4'd3, 64'd0, 64'hBAD);
        step();
        drive_m(SAOK, IIRMOVQ, 4'd1, RNONE, 64'h1111, 64'd0);
        step();
        step();
        step();
        drain_sb("freeze_rbx");
        checks++;
        if (Stat !== SADR || halted !== 1'b1) begin
            errors++;
            $display("FAIL freeze_stat: got Stat=%h halted=%b expected 3/1", Stat, halted);
        end
        checks++;
        if (W_stat !== SADR || W_dstM !== 4'd3 || W_valM !== 64'hBAD) begin
            errors++;
            $display("FAIL freeze_w: got stat=%h dstM=%h valM=%h expected 3/3/bad", W_stat, W_dstM, W_valM);
        end
        dbg_addr = 4'd1;
        #1;
        checks++;
        if (dbg_data !== model[1]) begin
            errors++;
            $display("FAIL freeze_rcx: got %h expected %h", dbg_data, model[1]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive_nop();
        for (int i = 0; i < 15; i++) model[i] = 64'd0;
        checks++;
        if (Stat !== SAOK || halted !== 1'b0 || W_stat !== SBUB) begin
            errors++;
            $display("FAIL freeze_rst: got Stat=%h halted=%b W_stat=%h expected 1/0/0", Stat, halted, W_stat);
        end
        for (int i = 0; i < 15; i++) begin
            dbg_addr = 4'(i);
            #1;
            checks++;
            if (dbg_data !== 64'd0) begin
                errors++;
                $display("FAIL freeze_rst_reg[%0d]: got %h expected 0", i, dbg_data);
            end
        end
        drive_m(SHLT, IHALT, RNONE, RNONE, 64'd0, 64'd0);
        step();
        drive_nop();
        step();
        checks++;
        if (Stat !== SHLT || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_stat: got Stat=%h halted=%b expected 2/1", Stat, halted);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive_m(SAOK, IIRMOVQ, 4'd0, RNONE, 64'h55, 64'd0);
        step();
        rst = 1'b1;
        drive_nop();
        step();
        rst = 1'b0;
        dbg_addr = 4'd0;
        #1;
        checks++;
        if (dbg_data !== 64'd0 || W_stat !== SBUB) begin
            errors++;
            $display("FAIL reset_mid: got rax=%h W_stat=%h expected 0/0", dbg_data, W_stat);
        end
        drive_m(SAOK, IIRMOVQ, RNONE, RNONE, 64'hFF, 64'hEE);
        step();
        drive_nop();
        step();
        d_srcB = RNONE;
        #1;
        checks++;
        if (d_rvalB !== 64'd0) begin
            errors++;
            $display("FAIL rnone_read: got %h expected 0", d_rvalB);
        end
        for (int i = 0; i < 15; i++) begin
            dbg_addr = 4'(i);
            #1;
            checks++;
            if (dbg_data !== model[i]) begin
                errors++;
                $display("FAIL rnone_nowrite reg[%0d]: got %h expected %h", i, dbg_data, model[i]);
            end
        end
        drive_m(SAOK, IIRMOVQ, 4'd14, RNONE, 64'hE14, 64'd0);
        push_exp(SAOK, 4'd14, RNONE, 64'hE14, 64'd0);
        step();
        drive_nop();
        step();
        drain_sb("reg14");
    endtask

    initial begin
        test_reset();
        test_irmovq();
        test_popq();
        test_stall_bubble();
        test_freeze();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
